// File: rtl/fifo_uart_tx_pkg.sv
// Shared constants for the FIFO-fed UART transmitter: FSM state encoding
// and parity-type values.
package fifo_uart_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// every serial bit; held at zero while clear is high.
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_done = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining the read side of the async FIFO: pops a word
// whenever one is available and sends start, data LSB-first, parity, stop.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_r_inc,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int IW = $clog2(DATA_WIDTH) + 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] shift;
  logic [IW-1:0]         bit_idx;
  logic                  par_en_q;
  logic                  par_bit;
  logic                  bit_done;
  logic                  capture;

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == ST_IDLE),
    .bit_done(bit_done)
  );

  // A word is taken from IDLE or on the final stop cycle, so frames chain
  // with no idle gap; reset gating keeps the pop strobe quiet in reset.
  assign capture    = ((state == ST_IDLE) || ((state == ST_STOP) && bit_done)) && !fifo_empty;
  assign fifo_r_inc = capture && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
    end else if (capture) begin
      state    <= ST_START;
      shift    <= fifo_rd_data;
      bit_idx  <= '0;
      par_en_q <= par_en;
      par_bit  <= (^fifo_rd_data) ^ (par_typ == PAR_ODD);
      tx_out   <= 1'b0;
      busy     <= 1'b1;
    end else if (bit_done) begin
      case (state)
        ST_START: begin
          state  <= ST_DATA;
          tx_out <= shift[0];
        end
        ST_DATA: begin
          if (bit_idx == LAST_BIT) begin
            if (par_en_q) begin
              state  <= ST_PARITY;
              tx_out <= par_bit;
            end else begin
              state  <= ST_STOP;
              tx_out <= 1'b1;
            end
          end else begin
            // The line is registered, so it takes the bit that moves into
            // position 0 on this same shift.
            shift   <= shift >> 1;
            tx_out  <= shift[1];
            bit_idx <= bit_idx + 1'b1;
          end
        end
        ST_PARITY: begin
          state  <= ST_STOP;
          tx_out <= 1'b1;
        end
        ST_STOP: begin
          state  <= ST_IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small behavioural FIFO on its read
// side; frames are sampled bit by bit and compared with hand-built vectors.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       fifo_r_inc;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic       tx_out;
  logic       busy;

  logic [7:0] mem [0:15];
  int         wrPtr = 0;
  int         rdPtr = 0;
  logic       gateEmpty = 1'b0;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int popCount = 0;
  int popWhileEmpty = 0;
  int lastPopCyc = 0;
  int popGap = 0;
  int busyRun = 0;
  int lastBusyRun = 0;

  fifo_uart_tx #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_r_inc  (fifo_r_inc),
    .par_en      (par_en),
    .par_typ     (par_typ),
    .tx_out      (tx_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  assign fifo_empty   = (wrPtr == rdPtr) || gateEmpty;
  assign fifo_rd_data = mem[rdPtr[3:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_r_inc) begin
      if (fifo_empty) popWhileEmpty <= popWhileEmpty + 1;
      rdPtr      <= rdPtr + 1;
      popCount   <= popCount + 1;
      popGap     <= cyc - lastPopCyc;
      lastPopCyc <= cyc;
    end
  end

  always @(negedge clk) begin
    if (busy) begin
      busyRun <= busyRun + 1;
    end else begin
      if (busyRun != 0) lastBusyRun <= busyRun;
      busyRun <= 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] word);
    mem[wrPtr[3:0]] = word;
    wrPtr = wrPtr + 1;
  endtask

  // Waits (bounded) for the pop strobe, then samples every cycle of the frame.
  task automatic expectFrame(input string tag, input logic [7:0] data,
                             input logic withPar, input logic parExp,
                             input int flipAt, output int waited);
    logic [31:0] expVec;
    logic [31:0] obsVec;
    int          nbits;
    int          glitches;
    int          k;
    expVec   = '0;
    obsVec   = '0;
    glitches = 0;
    waited   = 0;
    nbits    = withPar ? 11 : 10;
    expVec[8:1] = data;
    if (withPar) begin
      expVec[9]  = parExp;
      expVec[10] = 1'b1;
    end else begin
      expVec[9] = 1'b1;
    end
    #1;
    while (fifo_r_inc !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (fifo_r_inc !== 1'b1) begin
      checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
      return;
    end
    k = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (k == flipAt) par_typ = ~par_typ;
        if (c == 0) obsVec[b] = tx_out;
        else if (tx_out !== obsVec[b]) glitches++;
        k++;
      end
    end
    checkOutput({tag, "_bits"}, obsVec, expVec);
    checkOutput({tag, "_glitch"}, glitches, 0);
  endtask

  initial begin
    int waited;
    int pops;

    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_tx", tx_out, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_rinc", fifo_r_inc, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    begin
      int idleBad;
      idleBad = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (tx_out !== 1'b1 || busy !== 1'b0 || fifo_r_inc !== 1'b0) idleBad++;
      end
      checkOutput("idle_cycles_bad", idleBad, 0);
      checkOutput("idle_pops", popCount, 0);
    end

    pops = popCount;
    applyStimulus(8'hA5);
    expectFrame("a5", 8'hA5, 1'b0, 1'b0, -1, waited);
    repeat (2) @(negedge clk);
    checkOutput("a5_pops", popCount - pops, 1);
    checkOutput("a5_busy_len", lastBusyRun, 40);

    par_en = 1'b1;
    par_typ = 1'b0;
    applyStimulus(8'h07);
    expectFrame("par_even", 8'h07, 1'b1, 1'b1, -1, waited);
    repeat (2) @(negedge clk);
    checkOutput("par_even_busy_len", lastBusyRun, 44);

    par_typ = 1'b1;
    applyStimulus(8'h07);
    expectFrame("par_odd", 8'h07, 1'b1, 1'b0, -1, waited);
    repeat (2) @(negedge clk);

    par_typ = 1'b0;
    applyStimulus(8'h07);
    expectFrame("par_flip", 8'h07, 1'b1, 1'b1, 10, waited);
    repeat (2) @(negedge clk);
    par_en = 1'b0;
    par_typ = 1'b0;

    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    expectFrame("b2b_1", 8'h01, 1'b0, 1'b0, -1, waited);
    expectFrame("b2b_2", 8'h02, 1'b0, 1'b0, -1, waited);
    checkOutput("b2b_2_wait", waited, 0);
    checkOutput("b2b_2_gap", popGap, 40);
    expectFrame("b2b_3", 8'h03, 1'b0, 1'b0, -1, waited);
    checkOutput("b2b_3_wait", waited, 0);
    checkOutput("b2b_3_gap", popGap, 40);
    repeat (2) @(negedge clk);
    checkOutput("b2b_busy_len", lastBusyRun, 120);

    applyStimulus(8'h3C);
    applyStimulus(8'h5A);
    expectFrame("edge_1", 8'h3C, 1'b0, 1'b0, -1, waited);
    gateEmpty = 1'b1;
    pops = popCount;
    #1;
    checkOutput("edge_no_pop", fifo_r_inc, 1'b0);
    @(negedge clk);
    checkOutput("edge_idle_busy", busy, 1'b0);
    checkOutput("edge_idle_tx", tx_out, 1'b1);
    repeat (9) @(negedge clk);
    checkOutput("edge_pops_held", popCount - pops, 0);
    gateEmpty = 1'b0;
    expectFrame("edge_2", 8'h5A, 1'b0, 1'b0, -1, waited);
    checkOutput("edge_2_wait", waited, 0);
    repeat (2) @(negedge clk);

    applyStimulus(8'h96);
    #1;
    waited = 0;
    while (fifo_r_inc !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("rstmid_pop", fifo_r_inc, 1'b1);
    repeat (17) @(negedge clk);
    checkOutput("rstmid_bit3", tx_out, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_tx", tx_out, 1'b1);
    checkOutput("rstmid_busy", busy, 1'b0);
    applyStimulus(8'h55);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rstmid_rinc_in_reset", fifo_r_inc, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    expectFrame("after_rst", 8'h55, 1'b0, 1'b0, -1, waited);
    checkOutput("after_rst_wait", waited, 0);
    repeat (2) @(negedge clk);
    checkOutput("after_rst_busy_len", lastBusyRun, 40);

    checkOutput("pop_while_empty", popWhileEmpty, 0);
    checkOutput("fifo_drained", rdPtr, wrPtr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
